// File: rtl/trace_recorder.sv
// Multi-channel trigger-capture recorder: circular buffer with programmable pre-trigger depth, masked edge trigger,
// auto re-arm and oldest-first pop readback. Define TRACE_TIMESTAMP_EN to latch a 16-bit trigger timestamp.
module trace_recorder #(
  parameter int NCH   = 4,
  parameter int SW    = 4,
  parameter int NSRC  = 6,
  parameter int SEL_W = 3,
  parameter int AW    = 10
) (
  input  logic                  clk8M,
  input  logic                  reset_n,
  input  logic [NSRC*SW-1:0]    src_data,
  input  logic [NSRC-1:0]       det,
  input  logic [NCH*SEL_W-1:0]  ch_sel,
  input  logic                  enable,
  input  logic [NSRC-1:0]       trig_mask,
  input  logic                  force_trig,
  input  logic                  auto_rearm,
  input  logic [AW-1:0]         pre_depth,
  input  logic                  rd_restart,
  input  logic                  rd_pop,
  output logic [NCH*SW-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic [2:0]            state_o,
  output logic                  done,
  output logic [AW-1:0]         trig_addr,
  output logic [15:0]           trig_ts
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE_FILL = 3'd1,
    ARMED    = 3'd2,
    POST     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t              state;
  logic [NCH*SW-1:0]   mux_word;
  logic [NCH*SW-1:0]   stage_word;
  logic [NCH*SW-1:0]   wdata;
  logic [NSRC-1:0]     det_s;
  logic [NSRC-1:0]     det_q;
  logic                trig;
  logic [AW-1:0]       wr_addr;
  logic [AW-1:0]       rd_addr;
  logic [AW:0]         remaining;
  logic [AW-1:0]       pre_q;
  logic [AW-1:0]       pre_cnt;
  logic [AW-1:0]       post_cnt;
  logic [AW-1:0]       post_last;
  logic [AW-1:0]       start_addr;
  logic                wr_en;
  logic                pop_ok;
  logic                trig_accept;
  logic [NCH*SW-1:0]   mem [DEPTH];

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    mux_word = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < NSRC; k++) begin
        if (ch_sel[c*SEL_W +: SEL_W] == SEL_W'(k)) mux_word[c*SW +: SW] = src_data[k*SW +: SW];
      end
    end
  end

  // wdata and trig are aligned: both describe the staged sample from the cycle of the det edge.
  always_ff @(posedge clk8M or negedge reset_n) begin
    if (!reset_n) begin
      stage_word <= '0;
      wdata      <= '0;
      det_s      <= '0;
      det_q      <= '0;
      trig       <= 1'b0;
    end else begin
      stage_word <= mux_word;
      wdata      <= stage_word;
      det_s      <= det;
      det_q      <= det_s;
      trig       <= (|((det_s & ~det_q) & trig_mask)) | force_trig;
    end
  end

  assign wr_en       = (state == PRE_FILL) || (state == ARMED) || (state == POST);
  assign pop_ok      = enable && (state == DONE) && rd_pop && !rd_restart && (remaining != '0);
  assign trig_accept = enable && (state == ARMED) && trig;
  assign start_addr  = trig_addr - pre_q;
  assign post_last   = AW'(DEPTH - 2) - pre_q;
  assign rd_empty    = (remaining == '0);
  assign state_o     = state;

  // NOTE: the sample array has no reset so it maps onto block RAM; only its output register is reset.
  always_ff @(posedge clk8M) begin
    if (wr_en) mem[wr_addr] <= wdata;
  end

  always_ff @(posedge clk8M or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else if (pop_ok) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk8M or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wr_addr   <= '0;
      rd_addr   <= '0;
      remaining <= '0;
      pre_q     <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      done      <= 1'b0;
      trig_addr <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= pop_ok;
      if (wr_en) wr_addr <= wr_addr + AW'(1);
      if (!enable) begin
        state     <= IDLE;
        done      <= 1'b0;
        remaining <= '0;
      end else begin
        case (state)
          IDLE: begin
            state   <= PRE_FILL;
            pre_cnt <= '0;
            pre_q   <= pre_depth;
          end
          PRE_FILL: begin
            pre_cnt <= pre_cnt + AW'(1);
            if (pre_cnt == pre_q) state <= ARMED;
          end
          ARMED: begin
            if (trig) begin
              trig_addr <= wr_addr;
              post_cnt  <= '0;
              if (pre_q == AW'(DEPTH - 1)) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= POST;
              end
            end
          end
          POST: begin
            post_cnt <= post_cnt + AW'(1);
            if (post_cnt == post_last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            if (rd_restart) begin
              rd_addr   <= start_addr;
              remaining <= (AW+1)'(DEPTH);
            end else if (pop_ok) begin
              rd_addr   <= rd_addr + AW'(1);
              remaining <= remaining - (AW+1)'(1);
              // Draining the last sample re-arms; pre_depth keeps its value from the original arm.
              if (remaining == (AW+1)'(1) && auto_rearm) begin
                state   <= PRE_FILL;
                done    <= 1'b0;
                pre_cnt <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts_cnt;

  always_ff @(posedge clk8M or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt  <= '0;
      trig_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
      if (trig_accept) trig_ts <= ts_cnt;
    end
  end
`else
  assign trig_ts = '0;
`endif

endmodule

// File: doc/trace_recorder.md
Name: trace_recorder

Overview:
- Parametrised multi-channel trigger-capture recorder for sensor/converter streams; successor to the fixed 4-channel, 1024x4 trace capture.
- Each of NCH channels records one of NSRC source words into a DEPTH-entry circular buffer.
- Capture uses a programmable pre-trigger depth, an edge-detected masked trigger and optional auto re-arm.
- Readback is a synchronous pop interface on clk8M that returns the capture oldest-first.

Parameters:
- NCH, 4, number of recorded channels.
- SW, 4, sample width per channel (bits).
- NSRC, 6, number of selectable sources and trigger detect lines.
- SEL_W, 3, source select width per channel; must satisfy 2^SEL_W >= NSRC.
- AW, 10, buffer address width; DEPTH = 2^AW.

Ports:
- clk8M  in  1  capture and read clock.
- reset_n  in  1  reset.
- src_data  in  NSRC*SW  source words; source k at [k*SW +: SW].
- det  in  NSRC  detect lines (trigger sources).
- ch_sel  in  NCH*SEL_W  per-channel source index; index >= NSRC records 0.
- enable  in  1  recorder enable.
- trig_mask  in  NSRC  trigger source mask.
- force_trig  in  1  software trigger pulse.
- auto_rearm  in  1  re-arm automatically after full readback.
- pre_depth  in  AW  samples kept before the trigger sample, range 0..DEPTH-1.
- rd_restart  in  1  load read pointer at oldest sample.
- rd_pop  in  1  read request.
- rd_data  out  NCH*SW  read word; channel c at [c*SW +: SW].
- rd_valid  out  1  rd_data updated this cycle.
- rd_empty  out  1  no unread samples remain.
- state_o  out  3  FSM state.
- done  out  1  capture complete.
- trig_addr  out  AW  buffer address of the trigger sample.
- trig_ts  out  16  timestamp of the trigger (see Optional Feature).

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk8M.
- Reset values: all outputs 0, except rd_empty=1. State IDLE. wr_addr=0, rd_addr=0.
- Stage register: every cycle, each channel latches its mux-selected src_data word, and det is latched into det_s. det_q holds the previous det_s.
- Trigger event: trig = |((det_s & ~det_q) & trig_mask) | force_trig (registered). The trigger sample is the staged word from the same cycle as the det edge.
- Write: when state is PRE_FILL, ARMED or POST, the staged word is written at wr_addr and wr_addr increments mod DEPTH. wr_addr is never cleared except by reset.
- State encoding: IDLE=0, PRE_FILL=1, ARMED=2, POST=3, DONE=4.
- IDLE -> PRE_FILL when enable=1; pre_cnt is cleared.
- PRE_FILL: pre_cnt increments each write; triggers are ignored. Go to ARMED when pre_cnt == pre_depth. With pre_depth=0, go to ARMED on the first cycle.
- ARMED: on trig, trig_addr <= wr_addr and post_cnt <= 0. Go to DONE if pre_depth == DEPTH-1, else go to POST.
- POST: post_cnt increments each write. Go to DONE after the write where post_cnt reaches DEPTH-2-pre_depth.
- Capture size: exactly DEPTH samples. Oldest sample is at start_addr = trig_addr - pre_depth (mod DEPTH).
- DONE: done=1 and writes stop. If auto_rearm=1 and rd_empty rises after a full readback, go to PRE_FILL and set done=0.
- Any state, enable=0: go to IDLE next cycle and clear done. Unread data is discarded (rd_empty=1).
- pre_depth is sampled at the IDLE->PRE_FILL transition; later changes have no effect until the next arm.
- Read operations act only in DONE.
- rd_restart: rd_addr <= start_addr and remaining <= DEPTH.
- rd_pop with remaining > 0: on the next cycle rd_data = mem[rd_addr] and rd_valid=1 for one cycle; rd_addr increments mod DEPTH and remaining decrements.
- rd_pop with remaining == 0, or outside DONE: ignored; rd_valid stays 0.
- rd_restart and rd_pop in the same cycle: restart wins and the pop is dropped.
- rd_data holds its value between pops.
- rd_empty = (remaining == 0).
- Buffer: inferred simple dual-port RAM, one write port and one registered read port. Do not instantiate vendor primitives.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- When defined: a 16-bit free-running counter (reset 0, wraps) is latched into trig_ts in the cycle trig is accepted in ARMED. trig_ts holds its value until the next trigger.
- When not defined: trig_ts is tied to 0 and no counter logic exists.

Test Plan:
- Bench parameters: AW=4 (DEPTH=16), ch_sel={3,2,1,0}, src_data ramp. pre_depth=4, enable=1, det[0] rises at ramp value 20 with mask=1 -> done=1. After rd_restart, 16 pops return channel-0 values 16..31, with the trigger sample at pop index 4. rd_empty=1 after pop 16.
- det rises on bits 1 and 2 while PRE_FILL is still counting (pre_depth=8), mask=0x3F -> no trigger accepted. The first det[2] edge after reaching ARMED sets trig_addr.
- pre_depth=15 with force_trig -> DONE on the cycle after the trigger. Oldest sample = trig_addr+1, and the trigger sample is read last.
- enable dropped in POST -> IDLE next cycle, done=0, rd_pop yields no rd_valid. Re-enable -> PRE_FILL.
- auto_rearm=1 and 16 pops drain the buffer -> state PRE_FILL, done=0. A 17th pop is ignored.
- With TRACE_TIMESTAMP_EN defined, force_trig at counter value 0x0123 -> trig_ts = 0x0123. Without the macro, trig_ts = 0.
